// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: op codes, FSM states, op decode helpers.
// Latency: n/a (package).
// Backpressure: n/a (package).
package alu_pkg;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_SLL  = 4'd2;
   localparam logic [3:0] OP_SLT  = 4'd3;
   localparam logic [3:0] OP_SLTU = 4'd4;
   localparam logic [3:0] OP_XOR  = 4'd5;
   localparam logic [3:0] OP_SRL  = 4'd6;
   localparam logic [3:0] OP_SRA  = 4'd7;
   localparam logic [3:0] OP_OR   = 4'd8;
   localparam logic [3:0] OP_AND  = 4'd9;

   localparam int NUM_ALU_OPS = 10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // Codes 10..15 have no ALU function behind them.
   function automatic logic op_legal(input logic [3:0] op);
      return (op < 4'(NUM_ALU_OPS));
   endfunction

   // One-hot enable vector, bit k drives the enable of op code k; illegal codes give all zeros.
   function automatic logic [NUM_ALU_OPS-1:0] op_decode(input logic [3:0] op);
      logic [NUM_ALU_OPS-1:0] d;
      d = '0;
      case (op)
         OP_ADD:  d[0] = 1'b1;
         OP_SUB:  d[1] = 1'b1;
         OP_SLL:  d[2] = 1'b1;
         OP_SLT:  d[3] = 1'b1;
         OP_SLTU: d[4] = 1'b1;
         OP_XOR:  d[5] = 1'b1;
         OP_SRL:  d[6] = 1'b1;
         OP_SRA:  d[7] = 1'b1;
         OP_OR:   d[8] = 1'b1;
         OP_AND:  d[9] = 1'b1;
         default: d = '0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/alu_issue_ctrl_rr_arbiter.sv
// Round-robin arbiter: picks the first set request at or after the pointer, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides when a grant is consumed and advances the pointer.
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int ID_W    = 1
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [ID_W-1:0]    i_ptr,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [ID_W-1:0]    o_idx,
   output logic               o_any
);

   // Scan requesters starting at the pointer; the first hit wins.
   always_comb begin
      int c;
      o_grant = '0;
      o_idx   = '0;
      o_any   = 1'b0;
      c       = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         c = int'(i_ptr) + k;
         if (c >= NUM_REQ) begin
            c = c - NUM_REQ;
         end
         if (!o_any && i_req[c]) begin
            o_any      = 1'b1;
            o_grant[c] = 1'b1;
            o_idx      = ID_W'(c);
         end
      end
   end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Shares one combinational ALU between NUM_REQ requesters with round-robin grant and tagged response.
// Latency: accept edge -> rsp_valid after EXEC_CYCLES edges; one op per EXEC_CYCLES+2 cycles at best.
// Backpressure: req_ready only in IDLE; response held until rsp_ready, no new grant until the cycle after.
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter int NUM_REQ     = 2,
   parameter int ID_W        = 1,
   parameter int EXEC_CYCLES = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_REQ-1:0]    req_valid,
   output logic [NUM_REQ-1:0]    req_ready,
   input  logic [4*NUM_REQ-1:0]  req_op,
   input  logic [32*NUM_REQ-1:0] req_rs1,
   input  logic [32*NUM_REQ-1:0] req_rs2,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [ID_W-1:0]       rsp_id,
   output logic [31:0]           rsp_data,
   output logic                  rsp_err,
   output logic                  add_en,
   output logic                  sub_en,
   output logic                  sll_en,
   output logic                  slt_en,
   output logic                  sltu_en,
   output logic                  xor_en,
   output logic                  srl_en,
   output logic                  sra_en,
   output logic                  or_en,
   output logic                  and_en,
   output logic [31:0]           alu_rs1,
   output logic [31:0]           alu_rs2,
   input  logic [31:0]           alu_rd
);

   localparam int               CNT_W    = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXEC_CYCLES - 1);
   localparam logic [ID_W-1:0]  LAST_IDX = ID_W'(NUM_REQ - 1);

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [ID_W-1:0]        r_rr_ptr;
   logic [CNT_W-1:0]       r_cnt;
   logic [NUM_ALU_OPS-1:0] r_en;
   logic [31:0]            r_alu_rs1;
   logic [31:0]            r_alu_rs2;
   logic                   r_legal;
   logic [ID_W-1:0]        r_id;
   logic                   r_rsp_valid;
   logic [31:0]            r_rsp_data;
   logic                   r_rsp_err;
   logic [ID_W-1:0]        r_rsp_id;

   logic [NUM_REQ-1:0]     w_grant;
   logic [ID_W-1:0]        w_gnt_idx;
   logic                   w_gnt_any;
   logic [ID_W-1:0]        w_next_ptr;
   logic [3:0]             w_op;
   logic [31:0]            w_rs1;
   logic [31:0]            w_rs2;
   logic                   w_accept;
   logic                   w_exec_last;
   logic                   w_rsp_done;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_arb (
      .i_req   (req_valid),
      .i_ptr   (r_rr_ptr),
      .o_grant (w_grant),
      .o_idx   (w_gnt_idx),
      .o_any   (w_gnt_any)
   );

   // Ready is only offered in IDLE and is forced low while reset is asserted.
   assign req_ready  = (r_state == ST_IDLE && !rst) ? w_grant : '0;
   assign w_next_ptr = (w_gnt_idx == LAST_IDX) ? '0 : w_gnt_idx + ID_W'(1);

   // Select the granted requester's op and operands (one-hot grant, so the last hit is the only hit).
   always_comb begin
      w_op  = '0;
      w_rs1 = '0;
      w_rs2 = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_grant[i]) begin
            w_op  = req_op[4*i +: 4];
            w_rs1 = req_rs1[32*i +: 32];
            w_rs2 = req_rs2[32*i +: 32];
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic and the per-cycle event strobes that steer the datapath.
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_exec_last = 1'b0;
      w_rsp_done  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_gnt_any) begin
               w_accept    = 1'b1;
               w_state_nxt = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (r_cnt == '0) begin
               w_exec_last = 1'b1;
               w_state_nxt = ST_RESP;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               w_rsp_done  = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Issue side: latch the granted op into registered enables/operands, count the exec window.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rr_ptr  <= '0;
         r_cnt     <= '0;
         r_en      <= '0;
         r_alu_rs1 <= '0;
         r_alu_rs2 <= '0;
         r_legal   <= 1'b0;
         r_id      <= '0;
      end else if (w_accept) begin
         r_rr_ptr  <= w_next_ptr;
         r_cnt     <= CNT_LOAD;
         r_en      <= op_decode(w_op);
         r_alu_rs1 <= w_rs1;
         r_alu_rs2 <= w_rs2;
         r_legal   <= op_legal(w_op);
         r_id      <= w_gnt_idx;
      end else if (w_exec_last) begin
         r_en      <= '0;
         r_alu_rs1 <= '0;
         r_alu_rs2 <= '0;
      end else if (r_state == ST_EXEC) begin
         r_cnt     <= r_cnt - CNT_W'(1);
      end
   end

   // Response side: capture the ALU result on the last exec edge and hold it until handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
         r_rsp_err   <= 1'b0;
         r_rsp_id    <= '0;
      end else if (w_exec_last) begin
         r_rsp_valid <= 1'b1;
         r_rsp_data  <= r_legal ? alu_rd : '0;
         r_rsp_err   <= ~r_legal;
         r_rsp_id    <= r_id;
      end else if (w_rsp_done) begin
         r_rsp_valid <= 1'b0;
      end
   end

   assign rsp_valid = r_rsp_valid;
   assign rsp_data  = r_rsp_data;
   assign rsp_err   = r_rsp_err;
   assign rsp_id    = r_rsp_id;
   assign alu_rs1   = r_alu_rs1;
   assign alu_rs2   = r_alu_rs2;
   assign add_en    = r_en[0];
   assign sub_en    = r_en[1];
   assign sll_en    = r_en[2];
   assign slt_en    = r_en[3];
   assign sltu_en   = r_en[4];
   assign xor_en    = r_en[5];
   assign srl_en    = r_en[6];
   assign sra_en    = r_en[7];
   assign or_en     = r_en[8];
   assign and_en    = r_en[9];

endmodule
